// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency-meter front end.
package freq_meter_pkg;
  localparam int AXI_DATA_W = 32;
  localparam int ID_W       = 8;
  localparam int CNT_W      = 24;
  localparam logic [ID_W-1:0] SSEG_ID = 8'h7F;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [CNT_W-1:0] count;
  } meter_beat_t;
endpackage

// File: rtl/axi_if.sv
// Single-beat AXI-Stream link from the meter to the display path.
interface axi_if;
  import freq_meter_pkg::*;
  logic                  tvalid;
  logic                  tready;
  logic [AXI_DATA_W-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/edge_counter.sv
// Pulse conditioning, rising-edge detect and saturating edge counter.
// TOP_COUNTER_SYNC_EN adds a 2-flop synchronizer ahead of the edge detector.
module edge_counter #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic             pulse_q, pulse_dly_q, edge_w;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef TOP_COUNTER_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], pulse_i};
  end
  always_ff @(posedge clk) begin
    if (rst) pulse_q <= 1'b0;
    else     pulse_q <= sync_q[1];
  end
`else
  always_ff @(posedge clk) begin
    if (rst) pulse_q <= 1'b0;
    else     pulse_q <= pulse_i;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) pulse_dly_q <= 1'b0;
    else     pulse_dly_q <= pulse_q;
  end

  assign edge_w = pulse_q & ~pulse_dly_q;

  // cnt_d already includes an edge seen in the closing cycle, so the top
  // captures it as the final count while the register restarts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (edge_w && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) cnt_q <= '0;
    else              cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_d;
endmodule

// File: rtl/top_counter_freq.sv
// Frequency meter: counts pulse edges per gate window, emits one AXI-Stream beat per window.
// Optional build macro TOP_COUNTER_SYNC_EN (see edge_counter).
module top_counter_freq #(
  parameter int          CYCLLES_COUNT_MAX = 100,
  parameter logic [7:0]  DEST_ID           = freq_meter_pkg::SSEG_ID,
  parameter int          CNT_W             = freq_meter_pkg::CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse_signal,
  axi_if.master axi
);
  import freq_meter_pkg::*;

  localparam int GW = $clog2(CYCLLES_COUNT_MAX);
  localparam int PW = $bits(meter_beat_t) - ID_W;

  logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
  logic             close_w;
  logic [CNT_W-1:0] cnt_w;
  logic             tvalid_q, tvalid_d;
  meter_beat_t      tdata_q, tdata_d;

  assign close_w    = (gate_cnt_q == GW'(CYCLLES_COUNT_MAX - 1));
  assign gate_cnt_d = close_w ? '0 : gate_cnt_q + GW'(1);

  always_ff @(posedge clk) begin
    if (rst) gate_cnt_q <= '0;
    else     gate_cnt_q <= gate_cnt_d;
  end

  edge_counter #(.CNT_W(CNT_W)) u_edge_counter (
    .clk     (clk),
    .rst     (rst),
    .pulse_i (pulse_signal),
    .clr_i   (close_w),
    .cnt_o   (cnt_w)
  );

  // A close always (re)loads the output register: the latest result wins
  // over a beat still waiting on tready.
  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    if (tvalid_q && axi.tready) tvalid_d = 1'b0;
    if (close_w) begin
      tvalid_d      = 1'b1;
      tdata_d.id    = DEST_ID;
      tdata_d.count = PW'(cnt_w);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
    end else begin
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
    end
  end

  assign axi.tvalid = tvalid_q;
  assign axi.tdata  = tdata_q;
  assign axi.tlast  = tvalid_q;
endmodule

// File: tb/tb_top_counter_freq.sv
// Directed bench for top_counter_freq (window 100 clk, default build).
module tb_top_counter_freq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pulse = 1'b0;
  logic tready_r = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   k = 0;

  always #5 clk = ~clk;

  axi_if ax();
  axi_if ax_s();
  assign ax.tready   = tready_r;
  assign ax_s.tready = tready_r;

  top_counter_freq #(.CYCLLES_COUNT_MAX(100)) dut (
    .clk(clk), .rst(rst), .pulse_signal(pulse), .axi(ax)
  );

  // Narrow-counter instance, used to reach the saturation limit quickly.
  top_counter_freq #(.CYCLLES_COUNT_MAX(100), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .pulse_signal(pulse), .axi(ax_s)
  );

  // After tick, k counts clock edges since reset release.
  task automatic tick();
    @(posedge clk); #1; k++;
  endtask

  task automatic do_reset();
    rst = 1'b1; pulse = 1'b0;
    tick();
    rst = 1'b0; k = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tready_r = 1'b1;
    tick(); tick();
    checks++; if (ax.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", ax.tvalid); end
    checks++; if (ax.tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata: got %h want 00000000", ax.tdata); end
    checks++; if (ax.tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", ax.tlast); end
    checks++; if (ax_s.tvalid !== 1'b0) begin errors++; $display("FAIL reset_sat_tvalid: got %b want 0", ax_s.tvalid); end
  endtask

  // Period-2 pulse: 50 edges per window; the 4-bit instance saturates at 15.
  task automatic test_toggle();
    int early = 0;
    do_reset(); tready_r = 1'b1;
    while (k < 300) begin
      pulse = ((k + 1) % 2 == 1); tick();
      if (k % 100 == 0) begin
        checks++;
        if (ax.tvalid !== 1'b1 || ax.tdata !== 32'h7F00_0032 || ax.tlast !== 1'b1) begin
          errors++; $display("FAIL toggle_beat@%0d: got v=%b d=%h l=%b want v=1 d=7f000032 l=1", k, ax.tvalid, ax.tdata, ax.tlast);
        end
        checks++;
        if (ax_s.tvalid !== 1'b1 || ax_s.tdata !== 32'h7F00_000F) begin
          errors++; $display("FAIL saturate@%0d: got v=%b d=%h want v=1 d=7f00000f", k, ax_s.tvalid, ax_s.tdata);
        end
      end else if (ax.tvalid !== 1'b0) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL toggle_extra_beats: got %0d want 0", early); end
  endtask

  // Pulse stuck high: only the first rising edge is counted.
  task automatic test_hold_high();
    do_reset(); tready_r = 1'b1;
    while (k < 200) begin
      pulse = 1'b1; tick();
      if (k == 100) begin
        checks++; if (ax.tvalid !== 1'b1 || ax.tdata !== 32'h7F00_0001) begin errors++; $display("FAIL high_first: got v=%b d=%h want v=1 d=7f000001", ax.tvalid, ax.tdata); end
      end
      if (k == 200) begin
        checks++; if (ax.tvalid !== 1'b1 || ax.tdata !== 32'h7F00_0000) begin errors++; $display("FAIL high_second: got v=%b d=%h want v=1 d=7f000000", ax.tvalid, ax.tdata); end
      end
    end
  endtask

  task automatic test_period10();
    int beats[$];
    do_reset(); tready_r = 1'b1;
    while (k < 300) begin
      pulse = (((k + 1) % 10) < 5); tick();
      if (ax.tvalid === 1'b1) begin
        beats.push_back(k);
        checks++; if (ax.tdata !== 32'h7F00_000A) begin errors++; $display("FAIL p10_count@%0d: got %h want 7f00000a", k, ax.tdata); end
      end
    end
    checks++; if (beats.size() != 3) begin errors++; $display("FAIL p10_beats: got %0d want 3", beats.size()); end
    for (int i = 1; i < beats.size(); i++) begin
      checks++; if (beats[i] - beats[i-1] != 100) begin errors++; $display("FAIL p10_spacing: got %0d want 100", beats[i] - beats[i-1]); end
    end
  endtask

  // Single rising edge landing in the closing cycle, then in the first cycle of the next window.
  task automatic test_boundary();
    logic [31:0] exp1 [2];
    logic [31:0] exp2 [2];
    exp1[0] = 32'h7F00_0001; exp1[1] = 32'h7F00_0000;
    exp2[0] = 32'h7F00_0000; exp2[1] = 32'h7F00_0001;
    for (int t = 0; t < 2; t++) begin
      do_reset(); tready_r = 1'b1;
      while (k < 200) begin
        pulse = ((k + 1) >= 99 + t); tick();
        if (k == 100 || k == 200) begin
          checks++;
          if (ax.tvalid !== 1'b1 || ax.tdata !== (k == 100 ? exp1[t] : exp2[t])) begin
            errors++; $display("FAIL boundary%0d@%0d: got v=%b d=%h want v=1 d=%h", t, k, ax.tvalid, ax.tdata, (k == 100 ? exp1[t] : exp2[t]));
          end
        end
      end
    end
  endtask

  // Window 1: 50 edges, window 2: none, window 3: 10 edges; tready held low until k=250.
  task automatic test_backpressure();
    int xfers = 0, unstable = 0;
    do_reset(); tready_r = 1'b0;
    while (k < 300) begin
      if (k + 1 <= 100)      pulse = ((k + 1) % 2 == 1);
      else if (k + 1 <= 200) pulse = 1'b0;
      else                   pulse = (((k + 1 - 201) % 10) < 5);
      tick();
      if (k == 250) tready_r = 1'b1;
      if (k < 300 && ax.tvalid === 1'b1 && tready_r) xfers++;
      if (k >= 100 && k < 200 && (ax.tvalid !== 1'b1 || ax.tdata !== 32'h7F00_0032)) unstable++;
      if (k == 200) begin
        checks++; if (ax.tvalid !== 1'b1 || ax.tdata !== 32'h7F00_0000) begin errors++; $display("FAIL bp_overrun: got v=%b d=%h want v=1 d=7f000000", ax.tvalid, ax.tdata); end
      end
      if (k == 249) begin
        checks++; if (ax.tvalid !== 1'b1 || ax.tdata !== 32'h7F00_0000) begin errors++; $display("FAIL bp_hold: got v=%b d=%h want v=1 d=7f000000", ax.tvalid, ax.tdata); end
      end
      if (k == 251) begin
        checks++; if (ax.tvalid !== 1'b0) begin errors++; $display("FAIL bp_drop: got %b want 0", ax.tvalid); end
      end
      if (k == 300) begin
        checks++; if (ax.tvalid !== 1'b1 || ax.tdata !== 32'h7F00_000A) begin errors++; $display("FAIL bp_next: got v=%b d=%h want v=1 d=7f00000a", ax.tvalid, ax.tdata); end
      end
    end
    checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stable: got %0d bad cycles want 0", unstable); end
    checks++; if (xfers != 1) begin errors++; $display("FAIL bp_xfers: got %0d want 1", xfers); end
  endtask

  // Reset while a beat is pending and the window is 40 cycles in.
  task automatic test_reset_mid();
    int early = 0;
    do_reset(); tready_r = 1'b0;
    while (k < 140) begin pulse = ((k + 1) % 2 == 1); tick(); end
    checks++; if (ax.tvalid !== 1'b1) begin errors++; $display("FAIL mid_pending: got %b want 1", ax.tvalid); end
    rst = 1'b1; tick();
    checks++; if (ax.tvalid !== 1'b0 || ax.tdata !== 32'h0) begin errors++; $display("FAIL mid_rst_clear: got v=%b d=%h want v=0 d=00000000", ax.tvalid, ax.tdata); end
    rst = 1'b0; k = 0; tready_r = 1'b1;
    while (k < 100) begin
      pulse = ((k + 1) % 2 == 1); tick();
      if (k < 100 && ax.tvalid !== 1'b0) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL mid_early: got %0d want 0", early); end
    checks++; if (ax.tvalid !== 1'b1 || ax.tdata !== 32'h7F00_0032) begin errors++; $display("FAIL mid_full: got v=%b d=%h want v=1 d=7f000032", ax.tvalid, ax.tdata); end
  endtask

  task automatic test_random();
    int beats = 0;
    do_reset(); tready_r = 1'b1;
    while (k < 10000) begin
      pulse = ($urandom_range(0, 99) < 70); tick();
      if (ax.tvalid === 1'b1) begin
        beats++;
        checks++;
        if (ax.tdata[31:24] !== 8'h7F || ax.tlast !== 1'b1 || ax.tdata[23:0] > 24'd50) begin
          errors++; $display("FAIL rnd_beat@%0d: got d=%h l=%b want id=7f l=1 count<=50", k, ax.tdata, ax.tlast);
        end
      end
    end
    checks++; if (beats < 99 || beats > 100) begin errors++; $display("FAIL rnd_beats: got %0d want 99..100", beats); end
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_hold_high();
    test_period10();
    test_boundary();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
